alaw_packer: RTL and testbench

Byte-to-word packer downstream of the A-law coder. Takes the coder's 8-bit companded codes, one per `valid_in` strobe, and packs them little-endian into 32-bit words. Completed words go into a small first-word-fall-through FIFO with a valid/ready output, ready for the readout bus or SPI/DMA interface. A line-end marker flushes partial words, and byte enables are reported.

---
 rtl/alaw_packer.sv | 159 +++++++++++++++
 tb/tb_alaw_packer.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/alaw_packer.sv
// alaw_packer: packs A-law codes little-endian into words behind a FWFT output FIFO.
// Optional idle-timeout flush of partial words: define ALAW_PACKER_TIMEOUT_EN.
`default_nettype none

// +----------------------------------------------------------------------+
// | Module   : alaw_packer                                               |
// | Brief    : byte-to-word packer with line flush, keep lanes and FIFO  |
// | Options  : ALAW_PACKER_TIMEOUT_EN enables idle auto-flush            |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module alaw_packer #(
  parameter int DATA_IN_W  = 8,
  parameter int WORD_W     = 32,
  parameter int FIFO_DEPTH = 8,
  parameter int TIMEOUT    = 64
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [DATA_IN_W-1:0]             data_in,
  input  logic                             valid_in,
  input  logic                             last_in,
  output logic [WORD_W-1:0]                word_out,
  output logic [WORD_W/DATA_IN_W-1:0]      word_keep,
  output logic                             word_last,
  output logic                             word_valid,
  input  logic                             word_ready,
  output logic [$clog2(FIFO_DEPTH):0]      fill_level,
  output logic                             overflow,
  input  logic                             ovf_clear
);

  localparam int c_lanes   = WORD_W / DATA_IN_W;
  localparam int c_lane_w  = (c_lanes > 1) ? $clog2(c_lanes) : 1;
  localparam int c_addr_w  = $clog2(FIFO_DEPTH);
  localparam int c_fill_w  = c_addr_w + 1;
  localparam int c_entry_w = WORD_W + c_lanes + 1;
  localparam logic [c_lane_w-1:0] c_last_lane = c_lane_w'(c_lanes - 1);

  if ((WORD_W % DATA_IN_W) != 0 || FIFO_DEPTH < 2 ||
      (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || TIMEOUT < 2) begin : g_param_check
    $error("alaw_packer: illegal parameter combination");
  end

  // ---------------------------------------------------------------- packer
  logic [c_lane_w-1:0]  r_lane;
  logic [WORD_W-1:0]    r_acc;
  logic [c_lanes-1:0]   r_keep;
  logic [WORD_W-1:0]    w_acc_merged;
  logic [c_lanes-1:0]   w_keep_merged;
  logic [c_lanes-1:0]   w_hit;
  logic                 w_flush;
  logic                 w_push;
  logic [c_entry_w-1:0] w_push_entry;

  for (genvar g = 0; g < c_lanes; g++) begin : g_lane
    assign w_hit[g] = valid_in && (r_lane == c_lane_w'(g));
    assign w_acc_merged[g*DATA_IN_W +: DATA_IN_W] =
      w_hit[g] ? data_in : r_acc[g*DATA_IN_W +: DATA_IN_W];
    assign w_keep_merged[g] = w_hit[g] | r_keep[g];
  end

  // A timeout flush never coincides with valid_in, so the accumulator alone is pushed.
  assign w_push       = (valid_in && (r_lane == c_last_lane || last_in)) || w_flush;
  assign w_push_entry = valid_in ? {last_in, w_keep_merged, w_acc_merged}
                                 : {1'b0, r_keep, r_acc};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_lane <= '0;
      r_acc  <= '0;
      r_keep <= '0;
    end else if (w_push) begin
      r_lane <= '0;
      r_acc  <= '0;
      r_keep <= '0;
    end else if (valid_in) begin
      r_lane <= r_lane + 1'b1;
      r_acc  <= w_acc_merged;
      r_keep <= w_keep_merged;
    end
  end

`ifdef ALAW_PACKER_TIMEOUT_EN
  localparam int c_idle_w = $clog2(TIMEOUT) + 1;
  logic [c_idle_w-1:0] r_idle;

  assign w_flush = !valid_in && (r_lane != '0) && (r_idle == c_idle_w'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_idle <= '0;
    end else if (valid_in || w_flush || r_lane == '0) begin
      r_idle <= '0;
    end else begin
      r_idle <= r_idle + 1'b1;
    end
  end
`else
  assign w_flush = 1'b0;
`endif

  // ------------------------------------------------------------------ FIFO
  logic [c_entry_w-1:0] r_mem [FIFO_DEPTH];
  logic [c_addr_w-1:0]  r_wr_ptr;
  logic [c_addr_w-1:0]  r_rd_ptr;
  logic [c_fill_w-1:0]  r_count;
  logic                 r_overflow;
  logic                 w_full;
  logic                 w_pop;
  logic                 w_wr_en;
  logic                 w_drop;
  logic [c_entry_w-1:0] w_head;

  assign w_full  = (r_count == c_fill_w'(FIFO_DEPTH));
  assign w_pop   = word_valid && word_ready;
  // A pop frees the slot in the same edge, so a full FIFO can still accept.
  assign w_wr_en = w_push && (!w_full || w_pop);
  assign w_drop  = w_push && w_full && !w_pop;

  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mem[r_wr_ptr] <= w_push_entry;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_wr_en) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)   r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_wr_en, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (w_drop) begin
        r_overflow <= 1'b1;
      end else if (ovf_clear) begin
        r_overflow <= 1'b0;
      end
    end
  end

  // Head fields are forced to zero while empty so reset and drained states read 0.
  assign w_head     = r_mem[r_rd_ptr];
  assign word_valid = (r_count != '0);
  assign word_out   = word_valid ? w_head[WORD_W-1:0] : '0;
  assign word_keep  = word_valid ? w_head[WORD_W +: c_lanes] : '0;
  assign word_last  = word_valid ? w_head[c_entry_w-1] : 1'b0;
  assign fill_level = r_count;
  assign overflow   = r_overflow;

endmodule

`default_nettype wire

// File: tb/tb_alaw_packer.sv
// Self-checking bench for alaw_packer: vector table plus directed multi-cycle sequences.
`default_nettype none

module tb_alaw_packer;

  logic        tb_clk = 1'b0;
  logic        rst;
  logic [7:0]  data_in;
  logic        valid_in;
  logic        last_in;
  logic [31:0] word_out;
  logic [3:0]  word_keep;
  logic        word_last;
  logic        word_valid;
  logic        word_ready;
  logic [3:0]  fill_level;
  logic        overflow;
  logic        ovf_clear;

  int checks = 0;
  int errors = 0;

  always #5 tb_clk = ~tb_clk;

  alaw_packer #(
    .DATA_IN_W (8),
    .WORD_W    (32),
    .FIFO_DEPTH(8),
    .TIMEOUT   (64)
  ) dut (
    .clk       (tb_clk),
    .rst       (rst),
    .data_in   (data_in),
    .valid_in  (valid_in),
    .last_in   (last_in),
    .word_out  (word_out),
    .word_keep (word_keep),
    .word_last (word_last),
    .word_valid(word_valid),
    .word_ready(word_ready),
    .fill_level(fill_level),
    .overflow  (overflow),
    .ovf_clear (ovf_clear)
  );

  typedef struct {
    logic        v;
    logic        l;
    logic [7:0]  d;
    logic        rdy;
    logic        exp_valid;
    logic [31:0] exp_word;
    logic [3:0]  exp_keep;
    logic        exp_last;
    logic [3:0]  exp_fill;
  } vec_t;

  vec_t tbl [19];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step(input logic v, input logic l, input logic [7:0] d,
                      input logic rdy, input logic clr);
    @(negedge tb_clk);
    valid_in   = v;
    last_in    = l;
    data_in    = d;
    word_ready = rdy;
    ovf_clear  = clr;
    @(posedge tb_clk);
    #1;
  endtask

  function automatic logic [31:0] ramp_word(input int n);
    logic [7:0] b0, b1, b2, b3;
    b0 = 8'(4*n + 1);
    b1 = 8'(4*n + 2);
    b2 = 8'(4*n + 3);
    b3 = 8'(4*n + 4);
    return {b3, b2, b1, b0};
  endfunction

  initial begin
    int seen;
    logic [31:0] exp_w;

    // rows: v, last, data, ready | exp valid, word, keep, last, fill (after the edge)
    tbl[0]  = '{1'b1, 1'b0, 8'h11, 1'b1, 1'b0, 32'h0,        4'h0, 1'b0, 4'd0};
    tbl[1]  = '{1'b1, 1'b0, 8'h22, 1'b1, 1'b0, 32'h0,        4'h0, 1'b0, 4'd0};
    tbl[2]  = '{1'b1, 1'b0, 8'h33, 1'b1, 1'b0, 32'h0,        4'h0, 1'b0, 4'd0};
    tbl[3]  = '{1'b1, 1'b0, 8'h44, 1'b1, 1'b1, 32'h44332211, 4'hF, 1'b0, 4'd1};
    tbl[4]  = '{1'b1, 1'b0, 8'h55, 1'b1, 1'b0, 32'h0,        4'h0, 1'b0, 4'd0};
    tbl[5]  = '{1'b1, 1'b0, 8'h66, 1'b1, 1'b0, 32'h0,        4'h0, 1'b0, 4'd0};
    tbl[6]  = '{1'b1, 1'b0, 8'h77, 1'b1, 1'b0, 32'h0,        4'h0, 1'b0, 4'd0};
    tbl[7]  = '{1'b1, 1'b0, 8'h88, 1'b1, 1'b1, 32'h88776655, 4'hF, 1'b0, 4'd1};
    tbl[8]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 32'h88776655, 4'hF, 1'b0, 4'd1};
    tbl[9]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 32'h0,        4'h0, 1'b0, 4'd0};
    tbl[10] = '{1'b1, 1'b0, 8'hA1, 1'b0, 1'b0, 32'h0,        4'h0, 1'b0, 4'd0};
    tbl[11] = '{1'b1, 1'b1, 8'hB2, 1'b0, 1'b1, 32'h0000B2A1, 4'h3, 1'b1, 4'd1};
    tbl[12] = '{1'b1, 1'b0, 8'hC3, 1'b0, 1'b1, 32'h0000B2A1, 4'h3, 1'b1, 4'd1};
    tbl[13] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 32'h0,        4'h0, 1'b0, 4'd0};
    tbl[14] = '{1'b1, 1'b1, 8'hD4, 1'b0, 1'b1, 32'h0000D4C3, 4'h3, 1'b1, 4'd1};
    tbl[15] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 32'h0,        4'h0, 1'b0, 4'd0};
    tbl[16] = '{1'b0, 1'b1, 8'hFF, 1'b0, 1'b0, 32'h0,        4'h0, 1'b0, 4'd0};
    tbl[17] = '{1'b1, 1'b1, 8'hE5, 1'b0, 1'b1, 32'h000000E5, 4'h1, 1'b1, 4'd1};
    tbl[18] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 32'h0,        4'h0, 1'b0, 4'd0};

    rst        = 1'b0;
    valid_in   = 1'b0;
    last_in    = 1'b0;
    data_in    = 8'h00;
    word_ready = 1'b0;
    ovf_clear  = 1'b0;
    repeat (2) @(posedge tb_clk);
    #1;
    chk("reset outputs", 64'({word_out, word_keep, word_last, word_valid, fill_level, overflow}), 64'h0);
    @(negedge tb_clk);
    rst = 1'b1;

    // packing order, burst, line flush, last_in without valid_in
    for (int i = 0; i < 19; i++) begin
      step(tbl[i].v, tbl[i].l, tbl[i].d, tbl[i].rdy, 1'b0);
      chk($sformatf("row %0d valid/fill/ovf", i), 64'({word_valid, fill_level, overflow}),
          64'({tbl[i].exp_valid, tbl[i].exp_fill, 1'b0}));
      if (tbl[i].exp_valid)
        chk($sformatf("row %0d word/keep/last", i), 64'({word_out, word_keep, word_last}),
            64'({tbl[i].exp_word, tbl[i].exp_keep, tbl[i].exp_last}));
    end

    // backpressure: 10 words into a depth-8 FIFO
    for (int w = 0; w < 10; w++) begin
      for (int b = 0; b < 4; b++) step(1'b1, 1'b0, 8'(4*w + b + 1), 1'b0, 1'b0);
      if (w == 7) chk("full before drop", 64'({fill_level, overflow}), 64'({4'd8, 1'b0}));
    end
    chk("after drops fill/ovf", 64'({fill_level, overflow}), 64'({4'd8, 1'b1}));
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    chk("ovf_clear", 64'({fill_level, overflow}), 64'({4'd8, 1'b0}));

    // full FIFO with push and pop on the same edge
    step(1'b1, 1'b0, 8'hC0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 8'hC1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 8'hC2, 1'b0, 1'b0);
    step(1'b1, 1'b0, 8'hC3, 1'b1, 1'b0);
    chk("full push+pop fill/ovf", 64'({fill_level, overflow}), 64'({4'd8, 1'b0}));
    for (int i = 0; i < 8; i++) begin
      exp_w = (i < 7) ? ramp_word(i + 1) : 32'hC3C2C1C0;
      chk($sformatf("drain %0d head", i), 64'({word_valid, word_out, word_keep, word_last}),
          64'({1'b1, exp_w, 4'hF, 1'b0}));
      step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    end
    chk("drained", 64'({word_valid, fill_level}), 64'({1'b0, 4'd0}));

    // reset mid-line with 3 stored words and 2 pending codes
    for (int i = 0; i < 14; i++) step(1'b1, 1'b0, 8'(8'h40 + i), 1'b0, 1'b0);
    chk("pre-reset fill", 64'(fill_level), 64'd3);
    @(negedge tb_clk);
    valid_in = 1'b0;
    rst      = 1'b0;
    #1;
    chk("async reset outputs", 64'({word_out, word_keep, word_last, word_valid, fill_level, overflow}), 64'h0);
    @(negedge tb_clk);
    rst = 1'b1;
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 8'(8'h10 + i), 1'b0, 1'b0);
    chk("post-reset word", 64'({word_valid, word_out, word_keep, word_last, fill_level}),
        64'({1'b1, 32'h13121110, 4'hF, 1'b0, 4'd1}));
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    chk("post-reset drained", 64'({word_valid, fill_level}), 64'({1'b0, 4'd0}));

    // idle behaviour on a 3-code partial word
    step(1'b1, 1'b0, 8'h01, 1'b0, 1'b0);
    step(1'b1, 1'b0, 8'h02, 1'b0, 1'b0);
    step(1'b1, 1'b0, 8'h03, 1'b0, 1'b0);
    seen = 0;
`ifdef ALAW_PACKER_TIMEOUT_EN
    for (int n = 1; n <= 70 && seen == 0; n++) begin
      step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
      if (word_valid) seen = n;
    end
    chk("timeout latency", 64'(seen), 64'd64);
    chk("timeout word", 64'({word_out, word_keep, word_last, fill_level}),
        64'({32'h00030201, 4'h7, 1'b0, 4'd1}));
`else
    for (int n = 1; n <= 1000; n++) begin
      step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
      if (word_valid && seen == 0) seen = n;
    end
    chk("no timeout flush", 64'({seen, fill_level}), 64'({32'd0, 4'd0}));
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
